pcs_rx_block_lock: RTL

//  64b/66b receive block-lock stage (IEEE 802.3 Cl.49 style), directly downstream of the GT RX gearbox.

---
 rtl/pcs_rx_block_lock.sv | 117 +++++++++++
 1 files changed

// File: rtl/pcs_rx_block_lock.sv
// pcs_rx_block_lock: 64b/66b sync-header block lock with gearbox slip control
module pcs_rx_block_lock #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [1:0]  rx_header,
  input  logic [63:0] rx_data,
  output logic        rx_slip,
  output logic        block_lock,
  output logic        out_valid,
  output logic [1:0]  out_header,
  output logic [63:0] out_data,
  output logic [7:0]  slip_count,
  output logic [15:0] bad_sh_count
);
  typedef enum logic [1:0] {HUNT, SLIP, LOCKED} state_t;
  state_t state_q, state_d;
  logic [6:0] sh_cnt_q, sh_cnt_d;
  logic [4:0] invld_cnt_q, invld_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic rx_slip_q, rx_slip_d, block_lock_q, block_lock_d, out_valid_q, out_valid_d;
  logic [1:0] out_header_q, out_header_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0] slip_count_q, slip_count_d;
  logic [15:0] bad_sh_count_q, bad_sh_count_d;
  logic hdr_ok, slip_now;
  assign hdr_ok = ^rx_header;
  always_comb begin
    state_d = state_q;
    sh_cnt_d = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_cnt_d = '0;
    block_lock_d = block_lock_q;
    bad_sh_count_d = bad_sh_count_q;
    slip_now = 1'b0;
    if (state_q == SLIP) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q == 8'(SLIP_WAIT - 1)) begin
        state_d = HUNT;
        wait_cnt_d = '0;
        sh_cnt_d = '0;
        invld_cnt_d = '0;
      end
    end else if (rx_valid) begin
      sh_cnt_d = sh_cnt_q + 7'd1;
      if (state_q == HUNT) begin
        if (!hdr_ok) slip_now = 1'b1;
        else if (sh_cnt_q == 7'(SH_CNT_MAX - 1)) begin
          state_d = LOCKED;
          block_lock_d = 1'b1;
          sh_cnt_d = '0;
        end
      end else begin
        if (!hdr_ok) begin
          invld_cnt_d = invld_cnt_q + 5'd1;
          bad_sh_count_d = bad_sh_count_q + {15'd0, bad_sh_count_q != 16'hFFFF};
        end
        // loss of lock takes priority over a window rollover on the same header
        if (!hdr_ok && invld_cnt_q == 5'(SH_INVLD_MAX - 1)) slip_now = 1'b1;
        else if (sh_cnt_q == 7'(SH_CNT_MAX - 1)) begin
          sh_cnt_d = '0;
          invld_cnt_d = '0;
        end
      end
    end
    if (slip_now) begin
      state_d = SLIP;
      block_lock_d = 1'b0;
      sh_cnt_d = '0;
      invld_cnt_d = '0;
    end
    rx_slip_d = slip_now;
    slip_count_d = slip_count_q + {7'd0, slip_now && slip_count_q != 8'hFF};
    // the header that achieves lock and the one that loses it are both withheld
    out_valid_d = rx_valid & block_lock_q & block_lock_d;
    out_header_d = rx_valid ? rx_header : out_header_q;
    out_data_d = rx_valid ? rx_data : out_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      sh_cnt_q <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q <= '0;
      rx_slip_q <= 1'b0;
      block_lock_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_header_q <= '0;
      out_data_q <= '0;
      slip_count_q <= '0;
      bad_sh_count_q <= '0;
    end else begin
      state_q <= state_d;
      sh_cnt_q <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rx_slip_q <= rx_slip_d;
      block_lock_q <= block_lock_d;
      out_valid_q <= out_valid_d;
      out_header_q <= out_header_d;
      out_data_q <= out_data_d;
      slip_count_q <= slip_count_d;
      bad_sh_count_q <= bad_sh_count_d;
    end
  end
  assign rx_slip = rx_slip_q;
  assign block_lock = block_lock_q;
  assign out_valid = out_valid_q;
  assign out_header = out_header_q;
  assign out_data = out_data_q;
  assign slip_count = slip_count_q;
  assign bad_sh_count = bad_sh_count_q;
endmodule
